// File: rtl/vx_tcu_fedp_arb_if.sv
// ---------------------------------------------------------------------------
// vx_tcu_fedp_arb_if
// Groups every handshake and data bus of the FEDP arbiter in one bundle.
//   request side  : req_valid/req_ready plus per-requester formats, lane mask,
//                   A/B operands, accumulator and tag
//   FEDP side     : fedp_enable, granted mask/formats/operands/accumulator,
//                   fedp_d_val result returning from the FEDP unit
//   response side : rsp_valid (one-hot), rsp_ready, rsp_d_val, rsp_tag
// modport slave  : the arbiter
// modport master : the environment (requesters, FEDP unit, response sinks)
// ---------------------------------------------------------------------------
interface vx_tcu_fedp_arb_if #(
    parameter int NUM_REQS       = 4,
    parameter int N              = 2,
    parameter int TAG_W          = 4,
    parameter int TCU_MAX_INPUTS = 8
);
    logic [NUM_REQS-1:0]                     req_valid;
    logic [NUM_REQS-1:0]                     req_ready;
    logic [NUM_REQS-1:0][3:0]                req_fmt_s;
    logic [NUM_REQS-1:0][3:0]                req_fmt_d;
    logic [NUM_REQS-1:0][TCU_MAX_INPUTS-1:0] req_vld_mask;
    logic [NUM_REQS-1:0][N-1:0][31:0]        req_a_row;
    logic [NUM_REQS-1:0][N-1:0][31:0]        req_b_col;
    logic [NUM_REQS-1:0][31:0]               req_c_val;
    logic [NUM_REQS-1:0][TAG_W-1:0]          req_tag;

    logic                                    fedp_enable;
    logic [TCU_MAX_INPUTS-1:0]               fedp_vld_mask;
    logic [3:0]                              fedp_fmt_s;
    logic [3:0]                              fedp_fmt_d;
    logic [N-1:0][31:0]                      fedp_a_row;
    logic [N-1:0][31:0]                      fedp_b_col;
    logic [31:0]                             fedp_c_val;
    logic [31:0]                             fedp_d_val;

    logic [NUM_REQS-1:0]                     rsp_valid;
    logic [NUM_REQS-1:0]                     rsp_ready;
    logic [31:0]                             rsp_d_val;
    logic [TAG_W-1:0]                        rsp_tag;

    modport slave (
        input  req_valid, req_fmt_s, req_fmt_d, req_vld_mask, req_a_row, req_b_col,
               req_c_val, req_tag, fedp_d_val, rsp_ready,
        output req_ready, fedp_enable, fedp_vld_mask, fedp_fmt_s, fedp_fmt_d,
               fedp_a_row, fedp_b_col, fedp_c_val, rsp_valid, rsp_d_val, rsp_tag
    );

    modport master (
        output req_valid, req_fmt_s, req_fmt_d, req_vld_mask, req_a_row, req_b_col,
               req_c_val, req_tag, fedp_d_val, rsp_ready,
        input  req_ready, fedp_enable, fedp_vld_mask, fedp_fmt_s, fedp_fmt_d,
               fedp_a_row, fedp_b_col, fedp_c_val, rsp_valid, rsp_d_val, rsp_tag
    );
endinterface

// File: rtl/vx_tcu_fedp_arb.sv
// ---------------------------------------------------------------------------
// vx_tcu_fedp_arb
// Shares one fixed-latency FEDP unit among NUM_REQS requesters.
//   - round-robin grant, at most one issue per cycle, only while credits remain
//   - shadow pipeline of {valid, id, tag} shifted in lock-step with the FEDP
//   - results captured into an in-order response queue (OUT_DEPTH entries)
//   - credits = OUT_DEPTH - (in flight + queued), so capture never overflows
// Ports
//   clk   : clock
//   reset : synchronous, active-low reset
//   bus   : vx_tcu_fedp_arb_if.slave (request, FEDP and response buses)
// Build option
//   TCU_FEDP_ARB_QOS_EN : requester 0 gets strict priority; the others share
//                         round-robin and only their grants move the pointer.
// ---------------------------------------------------------------------------
module vx_tcu_fedp_arb #(
    parameter int NUM_REQS       = 4,
    parameter int N              = 2,
    parameter int LATENCY        = 4,
    parameter int TAG_W          = 4,
    parameter int OUT_DEPTH      = 8,
    parameter int TCU_MAX_INPUTS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    vx_tcu_fedp_arb_if.slave     bus
);

    localparam int ID_W  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

`ifdef TCU_FEDP_ARB_QOS_EN
    localparam bit QOS_EN = 1'b1;
`else
    localparam bit QOS_EN = 1'b0;
`endif

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic [TAG_W-1:0] tag;
    } shadow_t;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } entry_t;

    shadow_t          shadow_q [LATENCY];
    shadow_t          shadow_d [LATENCY];
    entry_t           queue_q  [OUT_DEPTH];
    entry_t           queue_d  [OUT_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] credits_q, credits_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic [ID_W-1:0]  grant_id_s;
    logic             issue_s;
    logic             in_flight_s;
    logic             capture_s;
    logic             pop_s;
    entry_t           head_s;

    // (base + off) mod NUM_REQS for off in [0, NUM_REQS]
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQS) begin
            sum = sum - NUM_REQS;
        end else begin
            sum = sum;
        end
        return ID_W'(sum);
    endfunction

    // Grant selection: first valid requester at or after the RR pointer, issue needs a credit
    always_comb begin
        grant_id_s = '0;
        issue_s    = 1'b0;
        if (reset && (credits_q != '0)) begin
`ifdef TCU_FEDP_ARB_QOS_EN
            if (bus.req_valid[0]) begin
                issue_s    = 1'b1;
                grant_id_s = '0;
            end else begin
                for (int k = 0; k < NUM_REQS; k++) begin
                    if (!issue_s && (wrap_add(rr_ptr_q, k) != '0) &&
                        bus.req_valid[wrap_add(rr_ptr_q, k)]) begin
                        issue_s    = 1'b1;
                        grant_id_s = wrap_add(rr_ptr_q, k);
                    end else begin
                        grant_id_s = grant_id_s;
                    end
                end
            end
`else
            for (int k = 0; k < NUM_REQS; k++) begin
                if (!issue_s && bus.req_valid[wrap_add(rr_ptr_q, k)]) begin
                    issue_s    = 1'b1;
                    grant_id_s = wrap_add(rr_ptr_q, k);
                end else begin
                    grant_id_s = grant_id_s;
                end
            end
`endif
        end else begin
            issue_s = 1'b0;
        end
    end

    // RR pointer advance; under QOS a requester-0 grant leaves it alone
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (issue_s && (!QOS_EN || (grant_id_s != '0))) begin
            rr_ptr_d = wrap_add(grant_id_s, 1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Ready one-hot on the winner and FEDP input mux; everything zero when nothing issues
    always_comb begin
        bus.req_ready     = '0;
        bus.fedp_vld_mask = '0;
        bus.fedp_fmt_s    = 4'd0;
        bus.fedp_fmt_d    = 4'd0;
        bus.fedp_a_row    = '0;
        bus.fedp_b_col    = '0;
        bus.fedp_c_val    = 32'd0;
        if (issue_s) begin
            bus.req_ready[grant_id_s] = 1'b1;
            bus.fedp_vld_mask         = bus.req_vld_mask[grant_id_s];
            bus.fedp_fmt_s            = bus.req_fmt_s[grant_id_s];
            bus.fedp_fmt_d            = bus.req_fmt_d[grant_id_s];
            bus.fedp_a_row            = bus.req_a_row[grant_id_s];
            bus.fedp_b_col            = bus.req_b_col[grant_id_s];
            bus.fedp_c_val            = bus.req_c_val[grant_id_s];
        end else begin
            bus.req_ready = '0;
        end
    end

    // FEDP runs whenever something issues or is still in flight, so it never stalls
    always_comb begin
        in_flight_s = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            in_flight_s = in_flight_s | shadow_q[i].valid;
        end
        bus.fedp_enable = issue_s | (reset & in_flight_s);
    end

    // Shadow pipeline next state, shifting in step with the FEDP
    always_comb begin
        for (int i = 0; i < LATENCY; i++) begin
            shadow_d[i] = shadow_q[i];
        end
        if (bus.fedp_enable) begin
            shadow_d[0].valid = issue_s;
            shadow_d[0].id    = grant_id_s;
            shadow_d[0].tag   = issue_s ? bus.req_tag[grant_id_s] : '0;
            for (int i = 1; i < LATENCY; i++) begin
                shadow_d[i] = shadow_q[i-1];
            end
        end else begin
            shadow_d[0] = shadow_q[0];
        end
    end

    // Response queue: capture at the shadow tail, pop only on the head owner's ready
    always_comb begin
        for (int i = 0; i < OUT_DEPTH; i++) begin
            queue_d[i] = queue_q[i];
        end
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        head_s    = queue_q[rd_ptr_q];
        capture_s = reset & shadow_q[LATENCY-1].valid;
        pop_s     = reset & (count_q != '0) & bus.rsp_ready[head_s.id];
        if (capture_s) begin
            queue_d[wr_ptr_q].id   = shadow_q[LATENCY-1].id;
            queue_d[wr_ptr_q].tag  = shadow_q[LATENCY-1].tag;
            queue_d[wr_ptr_q].data = bus.fedp_d_val;
            wr_ptr_d = (wr_ptr_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({capture_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Credit count: issue takes one now, a pop returns one from the next cycle on
    always_comb begin
        case ({issue_s, pop_s})
            2'b10:   credits_d = credits_q - CNT_W'(1);
            2'b01:   credits_d = credits_q + CNT_W'(1);
            default: credits_d = credits_q;
        endcase
    end

    // Head presentation toward the owning requester
    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_d_val = 32'd0;
        bus.rsp_tag   = '0;
        if (reset && (count_q != '0)) begin
            bus.rsp_valid[head_s.id] = 1'b1;
            bus.rsp_d_val            = head_s.data;
            bus.rsp_tag              = head_s.tag;
        end else begin
            bus.rsp_valid = '0;
        end
    end

    // Control state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                shadow_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            credits_q <= CNT_W'(OUT_DEPTH);
            rr_ptr_q  <= '0;
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            credits_q <= credits_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    // Queue payload storage; validity is tracked by the pointers, so no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < OUT_DEPTH; i++) begin
            queue_q[i] <= queue_d[i];
        end
    end

endmodule

// File: tb/tb_vx_tcu_fedp_arb.sv
// ---------------------------------------------------------------------------
// tb_vx_tcu_fedp_arb
// Drives the arbiter with directed and random traffic, emulates a LATENCY-deep
// FEDP unit (fp32 dot product built on reals), and checks every cycle against
// a transaction-level model: a list of in-flight ops with their due cycle and
// a list of queued responses, credits derived from the two list sizes.
// ---------------------------------------------------------------------------
module tb_vx_tcu_fedp_arb;
    localparam int NR    = 4;
    localparam int N     = 2;
    localparam int LAT   = 4;
    localparam int TAG_W = 4;
    localparam int DEPTH = 8;
    localparam int MAXI  = 8;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    vx_tcu_fedp_arb_if #(.NUM_REQS(NR), .N(N), .TAG_W(TAG_W), .TCU_MAX_INPUTS(MAXI)) bus ();

    vx_tcu_fedp_arb #(.NUM_REQS(NR), .N(N), .LATENCY(LAT), .TAG_W(TAG_W),
                      .OUT_DEPTH(DEPTH), .TCU_MAX_INPUTS(MAXI)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- fp32 helpers (normal numbers and zero) ----------------
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return 32'd0;
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] fedp_fn(input logic [MAXI-1:0] m, input logic [N-1:0][31:0] a,
                                            input logic [N-1:0][31:0] b, input logic [31:0] c);
        real s;
        s = f2r(c);
        for (int i = 0; i < N; i++) begin
            if (m[i]) s = s + f2r(a[i]) * f2r(b[i]);
        end
        return r2f(s);
    endfunction

    // ---------------- emulated FEDP unit ----------------
    logic [31:0] fp_pipe [LAT];
    always @(posedge clk) begin
        if (bus.fedp_enable) begin
            fp_pipe[0] <= fedp_fn(bus.fedp_vld_mask, bus.fedp_a_row, bus.fedp_b_col, bus.fedp_c_val);
            for (int i = 1; i < LAT; i++) fp_pipe[i] <= fp_pipe[i-1];
        end
    end
    assign bus.fedp_d_val = fp_pipe[LAT-1];

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int               id;
        logic [TAG_W-1:0] tag;
        logic [31:0]      d;
        int               due;
    } op_t;

    op_t infl[$];
    op_t rspq[$];
    int  ptr;
    int  cyc;

    function automatic int pick(input logic [NR-1:0] v, input int p);
`ifdef TCU_FEDP_ARB_QOS_EN
        if (v[0]) return 0;
`endif
        for (int k = 0; k < NR; k++) begin
            int j = (p + k) % NR;
`ifdef TCU_FEDP_ARB_QOS_EN
            if (j == 0) continue;
`endif
            if (v[j]) return j;
        end
        return -1;
    endfunction

    always @(negedge clk) begin : model_cmp
        int  g;
        int  credits;
        op_t op;
        cyc++;
        if (!reset) begin
            check("rst_req_ready", bus.req_ready, 64'd0);
            check("rst_rsp_valid", bus.rsp_valid, 64'd0);
            check("rst_fedp_en", bus.fedp_enable, 64'd0);
            check("rst_fedp_mask", bus.fedp_vld_mask, 64'd0);
            check("rst_fedp_c", bus.fedp_c_val, 64'd0);
            infl.delete();
            rspq.delete();
            ptr = 0;
        end else begin
            while (infl.size() > 0 && infl[0].due <= cyc) rspq.push_back(infl.pop_front());
            credits = DEPTH - infl.size() - rspq.size();
            g = (credits > 0) ? pick(bus.req_valid, ptr) : -1;
            check("req_ready", bus.req_ready, (g >= 0) ? 64'(1 << g) : 64'd0);
            check("fedp_enable", bus.fedp_enable, 64'((g >= 0) || (infl.size() > 0)));
            if (g >= 0) begin
                check("fedp_mask", bus.fedp_vld_mask, bus.req_vld_mask[g]);
                check("fedp_fmt", {bus.fedp_fmt_s, bus.fedp_fmt_d}, {bus.req_fmt_s[g], bus.req_fmt_d[g]});
                check("fedp_a", bus.fedp_a_row, bus.req_a_row[g]);
                check("fedp_b", bus.fedp_b_col, bus.req_b_col[g]);
                check("fedp_c", bus.fedp_c_val, bus.req_c_val[g]);
            end else begin
                check("fedp_idle_mask", bus.fedp_vld_mask, 64'd0);
                check("fedp_idle_c", bus.fedp_c_val, 64'd0);
            end
            if (rspq.size() > 0) begin
                check("rsp_valid", bus.rsp_valid, 64'(1 << rspq[0].id));
                check("rsp_d_val", bus.rsp_d_val, rspq[0].d);
                check("rsp_tag", bus.rsp_tag, rspq[0].tag);
                if (bus.rsp_ready[rspq[0].id]) op = rspq.pop_front();
            end else begin
                check("rsp_valid_empty", bus.rsp_valid, 64'd0);
            end
            if (g >= 0) begin
                op.id  = g;
                op.tag = bus.req_tag[g];
                op.d   = fedp_fn(bus.req_vld_mask[g], bus.req_a_row[g], bus.req_b_col[g], bus.req_c_val[g]);
                op.due = cyc + LAT + 1;
                infl.push_back(op);
`ifdef TCU_FEDP_ARB_QOS_EN
                if (g != 0) ptr = (g + 1) % NR;
`else
                ptr = (g + 1) % NR;
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] rnd_f();
        return r2f(real'($urandom_range(0, 14)) - 7.0);
    endfunction

    task automatic rand_data();
        for (int r = 0; r < NR; r++) begin
            bus.req_fmt_s[r]    = 4'($urandom);
            bus.req_fmt_d[r]    = 4'($urandom);
            bus.req_vld_mask[r] = 8'($urandom);
            for (int j = 0; j < N; j++) begin
                bus.req_a_row[r][j] = rnd_f();
                bus.req_b_col[r][j] = rnd_f();
            end
            bus.req_c_val[r] = rnd_f();
            bus.req_tag[r]   = TAG_W'($urandom);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        repeat (n) begin
            next();
            bus.req_valid = '0;
            bus.rsp_ready = '1;
        end
    endtask

    int          acc;
    int          en_cnt;
    logic        quiet;
    logic [NR-1:0] prev;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        ptr   = 0;
        reset = 1'b0;
        bus.req_valid = '1;
        bus.rsp_ready = '0;
        rand_data();
        repeat (3) @(posedge clk);
        #4;
        check("reset_req_ready", bus.req_ready, 64'd0);
        check("reset_fedp_en", bus.fedp_enable, 64'd0);

        // Single fp32 op: 1*3 + 2*4 + 1 = 12.0, tag 5, response 5 cycles later
        next();
        reset = 1'b1;
        bus.req_valid           = 4'b0001;
        bus.req_fmt_s[0]        = 4'd0;
        bus.req_fmt_d[0]        = 4'd0;
        bus.req_vld_mask[0]     = '1;
        bus.req_a_row[0][0]     = 32'h3F800000;
        bus.req_a_row[0][1]     = 32'h40000000;
        bus.req_b_col[0][0]     = 32'h40400000;
        bus.req_b_col[0][1]     = 32'h40800000;
        bus.req_c_val[0]        = 32'h3F800000;
        bus.req_tag[0]          = 4'd5;
        bus.rsp_ready           = '1;
        #3;
        check("t1_accept", bus.req_ready, 64'd1);
        for (int k = 1; k <= 5; k++) begin
            next();
            bus.req_valid = '0;
            #3;
            if (k == 4) check("t1_not_early", bus.rsp_valid, 64'd0);
            if (k == 5) begin
                check("t1_rsp_valid", bus.rsp_valid, 64'd1);
                check("t1_rsp_d", bus.rsp_d_val, 64'h41400000);
                check("t1_rsp_tag", bus.rsp_tag, 64'd5);
            end
        end

        // Reset re-centres the pointer, then all four requesters stream
        next();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            next();
            reset = 1'b1;
            bus.req_valid = '1;
            bus.rsp_ready = '1;
            rand_data();
            #3;
`ifdef TCU_FEDP_ARB_QOS_EN
            check("t2_grant", bus.req_ready, 64'd1);
`else
            check("t2_grant", bus.req_ready, 64'(1 << (i % 4)));
`endif
        end
        drain(10);

        // Credit exhaustion: exactly DEPTH accepts, then a single pop frees one slot next cycle
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            next();
            bus.req_valid = '1;
            bus.rsp_ready = '0;
            rand_data();
            #3;
            if (bus.req_ready != '0) acc++;
        end
        check("t3_accepts", 64'(acc), 64'(DEPTH));
        check("t3_blocked", bus.req_ready, 64'd0);
        next();
        bus.rsp_ready = '1;
        #3;
        check("t3_pop_same_cycle", bus.req_ready, 64'd0);
        next();
        bus.rsp_ready = '0;
        #3;
        check("t3_one_after_pop", 64'($countones(bus.req_ready)), 64'd1);
        next();
        #3;
        check("t3_blocked_again", bus.req_ready, 64'd0);
        drain(20);

        // Reset with three ops in flight drops them and restores all credits
        for (int i = 0; i < 3; i++) begin
            next();
            bus.req_valid = '1;
            bus.rsp_ready = '1;
            rand_data();
        end
        next();
        bus.req_valid = '0;
        reset = 1'b0;
        next();
        reset = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 12; i++) begin
            next();
            #3;
            if (bus.rsp_valid != '0) quiet = 1'b0;
        end
        check("t4_no_rsp", 64'(quiet), 64'd1);
        acc = 0;
        for (int i = 0; i < 15; i++) begin
            next();
            bus.req_valid = '1;
            bus.rsp_ready = '0;
            rand_data();
            #3;
            if (bus.req_ready != '0) acc++;
        end
        check("t4_accepts", 64'(acc), 64'(DEPTH));
        drain(20);

        // Requesters 0 and 2 only
        prev = '0;
        for (int i = 0; i < 8; i++) begin
            next();
            bus.req_valid = 4'b0101;
            bus.rsp_ready = '1;
            rand_data();
            #3;
`ifdef TCU_FEDP_ARB_QOS_EN
            check("t5_qos", bus.req_ready, 64'd1);
`else
            if (i == 0) check("t5_first", 64'((bus.req_ready == 4'b0001) || (bus.req_ready == 4'b0100)), 64'd1);
            else        check("t5_alt", bus.req_ready, (prev == 4'b0001) ? 64'd4 : 64'd1);
`endif
            prev = bus.req_ready;
        end

        // Enable tail after the last issue, then idle
        en_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            next();
            bus.req_valid = '0;
            #3;
            if (bus.fedp_enable) en_cnt++;
        end
        check("t6_enable_tail", 64'(en_cnt), 64'(LAT));
        check("t6_idle_enable", bus.fedp_enable, 64'd0);
        check("t6_idle_mask", bus.fedp_vld_mask, 64'd0);

        // Random traffic with backpressure and occasional reset
        for (int i = 0; i < 3000; i++) begin
            next();
            reset         = ($urandom_range(0, 399) != 0);
            bus.req_valid = NR'($urandom);
            bus.rsp_ready = NR'(~($urandom & $urandom));
            rand_data();
        end
        next();
        reset = 1'b1;
        drain(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
